serial_frame_rx: RTL and testbench

//  Receives a framed serial bitstream (start bit, N data bits LSB first, optional parity, stop bit),
//  as produced by the serializer, and recovers the data word into a parallel holding register.

---
 rtl/serial_frame_rx.sv | 135 +++++++++++++
 tb/tb_serial_frame_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: framed serial receiver.
// A frame is a start bit (0), N data bits sent LSB first, an optional parity bit
// and a stop bit (1). The recovered word goes into a single holding register and
// is offered on a valid/ready handshake. Frame and parity error flags travel with
// the word. If a word completes while the holding register is still full and the
// consumer is not taking it in that same cycle, the new word is dropped and
// overrun_o pulses for one cycle.
// The bit strobe (bit_en_i) only gates the frame FSM. The output handshake is
// evaluated on every clock.
module serial_frame_rx #(
  parameter int unsigned N          = 8,
  parameter int unsigned PARITY_EN  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         bit_en_i,
  input  logic         serial_i,
  output logic [N-1:0] data_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         frame_err_o,
  output logic         parity_err_o,
  output logic         overrun_o,
  output logic         busy_o
);

  // Counter width. Kept at 1 bit minimum so that N=1 still elaborates.
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
  localparam logic PAR_EN  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [N-1:0]  shreg;
  logic          par_err;

  // Next value of the shift register. Each new bit enters at the MSB, so after
  // N bits the first bit received (the LSB) has moved down to bit 0. It is
  // written with a shift and an OR so that it also works when N=1.
  logic [N-1:0]  shreg_nxt;
  // Parity check of the data word against the incoming parity bit.
  logic          par_chk;
  // The stop bit is sampled in this cycle, so the frame is complete.
  logic          complete;
  // The holding register can take a new word: it is empty, or it is being
  // emptied by an accept in this same cycle.
  logic          can_load;

  // Combinational helpers for the datapath and the handshake.
  always_comb begin
    shreg_nxt = (shreg >> 1) | ({{(N-1){1'b0}}, serial_i} << (N - 1));
    par_chk   = (^shreg) ^ serial_i ^ PAR_ODD;
    complete  = bit_en_i && (state == S_STOP);
    can_load  = !valid_o || ready_i;
  end

  // Frame FSM, bit counter and shift register. They change only on strobe cycles.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state   <= S_IDLE;
      cnt     <= '0;
      shreg   <= '0;
      par_err <= 1'b0;
    end else if (bit_en_i) begin
      case (state)
        S_IDLE: begin
          // A low line on a strobe is a start bit.
          if (!serial_i) begin
            state <= S_DATA;
            cnt   <= '0;
          end
        end
        S_DATA: begin
          shreg <= shreg_nxt;
          if (cnt == LAST_BIT) begin
            cnt   <= '0;
            state <= PAR_EN ? S_PARITY : S_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PARITY: begin
          par_err <= par_chk;
          state   <= S_STOP;
        end
        S_STOP: begin
          // The FSM returns to idle even after a bad (low) stop bit. If the
          // line stays low, the next strobe is taken as a new start bit.
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Holding register, valid/ready handshake and overrun pulse. Runs every clock.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_o       <= '0;
      valid_o      <= 1'b0;
      frame_err_o  <= 1'b0;
      parity_err_o <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (complete) begin
        if (can_load) begin
          // An accept and a load in the same cycle keep valid_o high with the new word.
          data_o       <= shreg;
          frame_err_o  <= ~serial_i;
          parity_err_o <= PAR_EN & par_err;
          valid_o      <= 1'b1;
        end else begin
          // Holding register is full and not being drained: drop the word.
          overrun_o <= 1'b1;
        end
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

  // busy_o is high whenever the FSM has left idle.
  always_comb begin
    busy_o = (state != S_IDLE);
  end

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: randomized and directed test of serial_frame_rx (N=8, even parity).
// The driver labels every bit it puts on the line with its role in the frame.
// The reference model only reacts to those labels. It goes busy at a start
// strobe. At a stop strobe it completes the word, whose value and error flags the
// bench computed itself when it built the frame. The output handshake is
// modelled from its rules.
module tb_serial_frame_rx;

  localparam int K_IDLE = 0, K_START = 1, K_DATA = 2, K_PAR = 3, K_STOP = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_en = 1'b0;
  logic       serial = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, parity_err_o, overrun_o, busy_o;

  int checks = 0;
  int failures = 0;

  // Driver side labels that the model reads.
  int         kind = K_IDLE;
  logic [7:0] cur_word = '0;
  logic       cur_perr = 1'b0;
  int         rdy_mode = 1;  // 0: random, 1: forced 0, 2: forced 1
  logic       chk_on = 1'b0;

  // Model state.
  logic       m_valid = 1'b0, m_ferr = 1'b0, m_perr = 1'b0, m_ovr = 1'b0, m_busy = 1'b0;
  logic [7:0] m_data = '0;

  serial_frame_rx #(.N(8), .PARITY_EN(1), .PARITY_ODD(0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bit_en_i(bit_en), .serial_i(serial),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready),
    .frame_err_o(frame_err_o), .parity_err_o(parity_err_o),
    .overrun_o(overrun_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model, updated at each active edge from the labelled inputs.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 0; m_data = '0; m_ferr = 0; m_perr = 0; m_ovr = 0; m_busy = 0;
    end else begin
      m_ovr = 0;
      if (bit_en && kind == K_START) m_busy = 1;
      if (bit_en && kind == K_STOP) begin
        m_busy = 0;
        if (!m_valid || ready) begin
          m_data = cur_word; m_ferr = !serial; m_perr = cur_perr; m_valid = 1;
        end else begin
          m_ovr = 1;
        end
      end else if (m_valid && ready) begin
        m_valid = 0;
      end
    end
  end

  // Compare process. It runs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("valid", valid_o, m_valid);
      chk("overrun", overrun_o, m_ovr);
      chk("busy", busy_o, m_busy);
      if (m_valid) begin
        chk("data", data_o, m_data);
        chk("frame_err", frame_err_o, m_ferr);
        chk("parity_err", parity_err_o, m_perr);
      end
    end
  end

  // Random ready, used only when rdy_mode is 0.
  always @(negedge clk) if (rdy_mode == 0) ready = 1'($urandom_range(0, 1));

  task automatic set_rdy(input int mode);
    rdy_mode = mode;
    if (mode == 1) ready = 1'b0;
    if (mode == 2) ready = 1'b1;
  endtask

  // One strobed bit, preceded by `gap` non-strobe cycles.
  task automatic send_bit(input logic v, input int k, input int gap);
    for (int i = 0; i < gap; i++) begin
      bit_en = 0; serial = v; kind = K_IDLE; @(negedge clk);
    end
    bit_en = 1; serial = v; kind = k; @(negedge clk);
    bit_en = 0; kind = K_IDLE;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            input int gap, input int idle);
    for (int i = 0; i < idle; i++) send_bit(1'b1, K_IDLE, gap);
    cur_word = d;
    cur_perr = (($countones(d) + int'(pbit)) % 2) != 0;
    send_bit(1'b0, K_START, gap);
    for (int i = 0; i < 8; i++) send_bit(d[i], K_DATA, gap);
    send_bit(pbit, K_PAR, gap);
    send_bit(stop, K_STOP, gap);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    // Reset.
    idle_cycles(2);
    chk_on = 1;
    chk("rst valid", valid_o, 0);
    chk("rst data", data_o, 0);
    chk("rst busy", busy_o, 0);
    chk("rst flags", {frame_err_o, parity_err_o, overrun_o}, 0);
    rst_n = 1;
    idle_cycles(2);

    // Basic word 0xA5 with correct even parity. valid_o must be up right after the stop edge.
    set_rdy(1);
    send_frame(8'hA5, 1'b0, 1'b1, 0, 0);
    chk("basic valid", valid_o, 1);
    chk("basic data", data_o, 8'hA5);
    chk("basic ferr", frame_err_o, 0);
    chk("basic perr", parity_err_o, 0);
    set_rdy(2); idle_cycles(1); set_rdy(1);
    chk("basic accepted", valid_o, 0);

    // Parity error.
    send_frame(8'hA5, 1'b1, 1'b1, 0, 1);
    chk("perr data", data_o, 8'hA5);
    chk("perr flag", parity_err_o, 1);
    chk("perr ferr", frame_err_o, 0);
    set_rdy(2); idle_cycles(1);

    // Frame error, then the line stays low: the next strobe is a start bit.
    send_frame(8'h3C, 1'b0, 1'b0, 0, 1);
    chk("ferr data", data_o, 8'h3C);
    chk("ferr flag", frame_err_o, 1);
    send_frame(8'h81, 1'b0, 1'b1, 0, 0);
    chk("b2b data", data_o, 8'h81);
    idle_cycles(2);

    // Overrun.
    set_rdy(1);
    send_frame(8'h11, 1'b0, 1'b1, 0, 1);
    send_frame(8'h22, 1'b0, 1'b1, 0, 0);
    chk("ovr pulse", overrun_o, 1);
    chk("ovr data kept", data_o, 8'h11);
    idle_cycles(1);
    chk("ovr one cycle", overrun_o, 0);
    set_rdy(2); idle_cycles(1); set_rdy(1);
    chk("ovr drained", valid_o, 0);

    // Strobe gating: bit_en_i high on one cycle in four.
    send_frame(8'h5A, 1'b0, 1'b1, 3, 1);
    chk("gated data", data_o, 8'h5A);

    // Reset partway through a frame, with a word still held.
    send_bit(1'b1, K_IDLE, 3);
    send_bit(1'b0, K_START, 3);
    for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i), K_DATA, 3);
    chk("mid busy", busy_o, 1);
    rst_n = 0; @(negedge clk); rst_n = 1;
    chk("rst mid busy", busy_o, 0);
    chk("rst mid valid", valid_o, 0);
    chk("rst mid data", data_o, 0);
    send_frame(8'h0F, 1'b0, 1'b1, 0, 1);
    chk("fresh data", data_o, 8'h0F);
    chk("fresh flags", {frame_err_o, parity_err_o}, 0);

    // Randomized frames with random ready.
    set_rdy(0);
    for (int f = 0; f < 60; f++) begin
      logic [7:0] d;
      logic pb, sb;
      d  = 8'($urandom);
      pb = ($urandom_range(0, 3) == 0) ? ~(^d) : (^d);
      sb = ($urandom_range(0, 4) != 0);
      send_frame(d, pb, sb, $urandom_range(0, 3), $urandom_range(0, 2));
    end
    set_rdy(2);
    idle_cycles(4);
    chk("final drained", valid_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
